cpu_core_seq: RTL and testbench
===============================

# cpu_core_seq

Fetch/decode/execute sequencer for the 16-bit CPU. Sits directly upstream of the combinational ALU: it fetches instructions from instruction memory over a req/ack handshake, reads a 7-entry register file plus the PC, drives the ALU's op and three operands from registers, and writes the ALU result back. The ALU itself stays a separate, unmodified instance; this block only drives its inputs and consumes its output.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held high until acked
- imem_addr  out  16  fetch address (= PC while imem_req high)
- imem_ack  in  1  memory accepted request; imem_data valid in same cycle
- imem_data  in  16  instruction word
- alu_op  out  3  ALU opcode
- alu_a / alu_b / alu_c  out  16 each  ALU operands ina/inb/inc
- alu_out  in  16  ALU result (combinational from alu_* outputs)
- pc  out  16  current PC
- halted  out  1  core stopped on HALT

## Operation
- Instruction format: [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [3:1] rc, [0] reserved (ignored).
- Register space: index 0-6 = R0-R6 (16-bit, reset 0); index 7 = PC. Reads of 7 return the PC of the executing instruction.
- Operand mapping: alu_op=op, alu_a=R[ra], alu_b=R[rb], alu_c=R[rc]; result written to R[rd].
- rd≠7: R[rd]<=alu_out, PC<=PC+1 (mod 2^16). rd=7: PC<=alu_out, no GPR write (branch/jump). Branch idiom: op 011/100 with ra=7, rd=7 gives PC+1 or target R[rb].
- op 111 = HALT: no write, PC unchanged, enter HALT; halted=1 until reset.
- FSM states: FETCH -> DECODE -> EXEC -> FETCH; EXEC -> HALT on op 111; HALT absorbing.
  - FETCH: imem_req=1, imem_addr=PC; on imem_ack latch imem_data into IR, go DECODE. No ack: stay, req and addr stable.
  - DECODE: register alu_op/alu_a/alu_b/alu_c from IR fields.
  - EXEC: sample alu_out, perform writeback and PC update, go FETCH (or HALT).
- imem_ack ignored outside FETCH.
- All arithmetic 16-bit, wrap-around, no flags.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, R0-R6=0, IR=0, imem_req=0, imem_addr=RESET_PC, alu_op=0, alu_a/b/c=0, halted=0.
- imem_req rises the first clock after rst deasserts.
- Minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC); each fetch wait cycle adds 1.
- alu_* registered outputs, stable for all of EXEC; alu_out must settle within EXEC cycle.
- Writeback visible to next instruction's DECODE (no hazards: strictly sequential).
- imem_req drops the cycle after ack; reasserts in next FETCH.
- rst mid-operation: everything returns to reset values immediately; in-flight fetch abandoned.

## Structure
- Shared package: opcode constants (OP_AND..OP_HALT), field bit positions, REG_PC=3'd7, state encoding.
- Sub-module: cpu_regfile (7x16, two... three combinational read ports plus PC mux, one write port, async reset).
- ALU instantiated by the enclosing top, not inside this block.

## Test plan
- Reset: hold rst, check all outputs at reset values; release -> imem_req=1, imem_addr=0000 next cycle.
- Increment: op 011 rd=1 ra=0 rc=0 at addr 0 -> R1=0001, PC=0001 after 3 cycles with zero-wait ack.
- Add: build R1=1, R2=2 via increments, then op 101 rd=3 ra=1 rb=2 -> R3=0003; op 010 rd=4 ra=3 -> R4=FFFC.
- Branch: R2=0010, R1=1; op 011 rd=7 ra=7 rb=2 rc=1 at PC 0005 -> PC=0010; with rc=0 -> PC=0006.
- Wait states: delay imem_ack 4 cycles -> imem_req/imem_addr stable throughout, instruction takes 7 cycles.
- HALT and reset mid-op: op 111 -> halted=1, imem_req stays 0 for 20 cycles; assert rst during DECODE of next test -> PC=0000, R*=0.

Source files
------------

// File: rtl/cpu_core_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_core_seq_pkg
// Shared definitions for the fetch/decode/execute sequencer: opcode values,
// instruction field positions and extractors, register-space constants and
// the sequencer state encoding.
// -----------------------------------------------------------------------------
package cpu_core_seq_pkg;

    // Opcodes carried in instr[15:13]; only OP_HALT changes sequencer behaviour,
    // the rest are passed straight through to the external ALU.
    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_NOT     = 3'b010;
    localparam logic [2:0] OP_SELINC  = 3'b011;
    localparam logic [2:0] OP_SELINCN = 3'b100;
    localparam logic [2:0] OP_ADD     = 3'b101;
    localparam logic [2:0] OP_SUB     = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    // Register index 7 aliases the PC; 0-6 are general purpose.
    localparam logic [2:0]  REG_PC  = 3'd7;
    localparam int unsigned NUM_GPR = 7;

    // LSB position of each 3-bit field; bit 0 is reserved.
    localparam int unsigned OP_LSB = 13;
    localparam int unsigned RD_LSB = 10;
    localparam int unsigned RA_LSB = 7;
    localparam int unsigned RB_LSB = 4;
    localparam int unsigned RC_LSB = 1;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StHalt   = 2'd3
    } state_e;

    function automatic logic [2:0] ir_op(input logic [15:0] ir);
        return ir[OP_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [15:0] ir);
        return ir[RD_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_ra(input logic [15:0] ir);
        return ir[RA_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_rb(input logic [15:0] ir);
        return ir[RB_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_rc(input logic [15:0] ir);
        return ir[RC_LSB +: 3];
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// -----------------------------------------------------------------------------
// cpu_regfile
// Seven 16-bit general-purpose registers with three combinational read ports
// and one synchronous write port. Read index 7 returns the supplied PC.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_pc                      PC value returned for read index 7
//   i_ra_sel/i_rb_sel/i_rc_sel read indices
//   o_ra_data/o_rb_data/o_rc_data read data
//   i_we, i_wr_sel, i_wr_data write enable, index (7 is ignored), data
// -----------------------------------------------------------------------------
module cpu_regfile
    import cpu_core_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_pc,
    input  logic [2:0]  i_ra_sel,
    input  logic [2:0]  i_rb_sel,
    input  logic [2:0]  i_rc_sel,
    output logic [15:0] o_ra_data,
    output logic [15:0] o_rb_data,
    output logic [15:0] o_rc_data,
    input  logic        i_we,
    input  logic [2:0]  i_wr_sel,
    input  logic [15:0] i_wr_data
);

    logic [NUM_GPR-1:0][15:0] r_regs;

    // Index 7 falls through every GPR compare and returns the PC.
    function automatic logic [15:0] read_port(input logic [2:0]               sel,
                                              input logic [NUM_GPR-1:0][15:0] regs,
                                              input logic [15:0]              pc);
        logic [15:0] data;
        data = pc;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (sel == 3'(i)) begin
                data = regs[i];
            end
        end
        return data;
    endfunction

    always_comb begin
        o_ra_data = read_port(i_ra_sel, r_regs, i_pc);
        o_rb_data = read_port(i_rb_sel, r_regs, i_pc);
        o_rc_data = read_port(i_rc_sel, r_regs, i_pc);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regs <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (i_wr_sel == 3'(i)) begin
                    r_regs[i] <= i_wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_core_seq.sv
// -----------------------------------------------------------------------------
// cpu_core_seq
// Fetch/decode/execute sequencer for the 16-bit CPU. Fetches an instruction
// over a req/ack handshake, registers ALU op and operands from the register
// file, then writes the ALU result back to a GPR or to the PC.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   o_imem_req, o_imem_addr fetch request (held until ack) and address (= PC)
//   i_imem_ack, i_imem_data fetch accept and instruction word (same cycle)
//   o_alu_op, o_alu_a/b/c   registered ALU opcode and operands
//   i_alu_out               combinational result from the external ALU
//   o_pc                    current PC
//   o_halted                set by HALT, cleared only by reset
// -----------------------------------------------------------------------------
module cpu_core_seq
    import cpu_core_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic [2:0]  o_alu_op,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [15:0] o_alu_c,
    input  logic [15:0] i_alu_out,
    output logic [15:0] o_pc,
    output logic        o_halted
);

    state_e      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic        r_imem_req;
    logic [2:0]  r_alu_op;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] r_alu_c;
    logic        r_halted;

    logic [15:0] w_ra_data;
    logic [15:0] w_rb_data;
    logic [15:0] w_rc_data;
    logic        w_is_halt;
    logic        w_rd_is_pc;
    logic        w_we;
    logic        w_unused_rsvd;

    assign w_is_halt     = (ir_op(r_ir) == OP_HALT);
    assign w_rd_is_pc    = (ir_rd(r_ir) == REG_PC);
    assign w_we          = (r_state == StExec) && !w_is_halt && !w_rd_is_pc;
    assign w_unused_rsvd = r_ir[0];

    cpu_regfile u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pc      (r_pc),
        .i_ra_sel  (ir_ra(r_ir)),
        .i_rb_sel  (ir_rb(r_ir)),
        .i_rc_sel  (ir_rc(r_ir)),
        .o_ra_data (w_ra_data),
        .o_rb_data (w_rb_data),
        .o_rc_data (w_rc_data),
        .i_we      (w_we),
        .i_wr_sel  (ir_rd(r_ir)),
        .i_wr_data (i_alu_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StFetch;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_c    <= '0;
            r_halted   <= 1'b0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    // Request is low only in the first FETCH after reset;
                    // an ack is accepted only once the request is visible.
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (i_imem_ack) begin
                        r_ir       <= i_imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= StDecode;
                    end
                end
                StDecode: begin
                    r_alu_op <= ir_op(r_ir);
                    r_alu_a  <= w_ra_data;
                    r_alu_b  <= w_rb_data;
                    r_alu_c  <= w_rc_data;
                    r_state  <= StExec;
                end
                StExec: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= StHalt;
                    end else begin
                        // GPR writeback happens in the regfile via w_we.
                        r_pc       <= w_rd_is_pc ? i_alu_out : r_pc + 16'd1;
                        // Raising req here lets the next FETCH complete in one cycle.
                        r_imem_req <= 1'b1;
                        r_state    <= StFetch;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_pc;
    assign o_alu_op    = r_alu_op;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_c     = r_alu_c;
    assign o_pc        = r_pc;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_cpu_core_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_core_seq
// Directed plus randomized bench for cpu_core_seq. An architectural model
// (register array, PC, halted flag) predicts every fetch address, ALU operand
// set and PC update. A behavioural ALU closes the loop on i_alu_out.
// -----------------------------------------------------------------------------
module tb_cpu_core_seq;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_c;
    logic [15:0] alu_out;
    logic [15:0] pc;
    logic        halted;

    int n_checks = 0;
    int n_err    = 0;

    // Architectural model state.
    logic [15:0] m_r [7];
    logic [15:0] m_pc;
    logic        m_halted;

    cpu_core_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_imem_req  (imem_req),
        .o_imem_addr (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .o_alu_op    (alu_op),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_c     (alu_c),
        .i_alu_out   (alu_out),
        .o_pc        (pc),
        .o_halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: ops 011/100 select between a+1 and b on c, as the branch idiom needs.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return (c != 16'd0) ? b : a + 16'd1;
            3'd4:    return (c != 16'd0) ? a + 16'd1 : b;
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_f(alu_op, alu_a, alu_b, alu_c);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        return (idx == 3'd7) ? m_pc : m_r[idx];
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int ra,
                                        input int rb, input int rc);
        return {3'(op), 3'(rd), 3'(ra), 3'(rb), 3'(rc), 1'($urandom)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_r[i] = 16'd0;
        m_pc     = 16'h0000;
        m_halted = 1'b0;
    endtask

    // Entered on a negedge with the DUT in FETCH and the request raised;
    // returns on the negedge after EXEC.
    task automatic exec(input logic [15:0] instr, input int waits);
        logic [2:0]  op, rd, ra, rb, rc;
        logic [15:0] res;
        op = instr[15:13];
        rd = instr[12:10];
        ra = instr[9:7];
        rb = instr[6:4];
        rc = instr[3:1];
        chk("fetch_req", 16'(imem_req), 16'd1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int w = 0; w < waits; w++) begin
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            @(negedge clk);
            chk("wait_req", 16'(imem_req), 16'd1);
            chk("wait_addr", imem_addr, m_pc);
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        @(negedge clk);
        // Junk handshakes outside FETCH must be ignored.
        imem_ack  = 1'($urandom);
        imem_data = 16'($urandom);
        chk("decode_req", 16'(imem_req), 16'd0);
        chk("decode_pc", pc, m_pc);
        @(negedge clk);
        imem_ack  = 1'($urandom);
        imem_data = 16'($urandom);
        chk("exec_op", 16'(alu_op), 16'(op));
        chk("exec_a", alu_a, m_read(ra));
        chk("exec_b", alu_b, m_read(rb));
        chk("exec_c", alu_c, m_read(rc));
        res = alu_f(op, m_read(ra), m_read(rb), m_read(rc));
        if (op == 3'd7) begin
            m_halted = 1'b1;
        end else if (rd == 3'd7) begin
            m_pc = res;
        end else begin
            m_r[rd] = res;
            m_pc    = m_pc + 16'd1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_pc", pc, m_pc);
        chk("post_halted", 16'(halted), 16'(m_halted));
        chk("post_req", 16'(imem_req), 16'(!m_halted));
    endtask

    initial begin
        rst       = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_op", 16'(alu_op), 16'd0);
        chk("rst_a", alu_a, 16'd0);
        chk("rst_b", alu_b, 16'd0);
        chk("rst_c", alu_c, 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("rel_req", 16'(imem_req), 16'd1);
        chk("rel_addr", imem_addr, 16'h0000);

        exec(enc(3, 1, 0, 0, 0), 0);   // R1 = 1
        exec(enc(3, 2, 1, 0, 0), 0);   // R2 = 2
        exec(enc(5, 3, 1, 2, 0), 0);   // R3 = 3
        exec(enc(2, 4, 3, 0, 0), 0);   // R4 = FFFC
        exec(enc(3, 7, 7, 2, 1), 0);   // taken: PC = R2
        exec(enc(3, 7, 7, 2, 0), 0);   // not taken: PC + 1
        exec(enc(4, 7, 7, 4, 0), 0);   // jump to FFFC
        for (int i = 0; i < 4; i++) exec(enc(3, 7, 7, 0, 0), 0);  // walk PC across wrap
        exec(enc(5, 5, 3, 4, 0), 4);   // four fetch wait cycles

        for (int i = 0; i < 40; i++) begin
            exec(enc($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7)),
                 $urandom_range(0, 3));
        end

        exec(enc(7, $urandom_range(0, 7), 1, 2, 3), 1);
        for (int i = 0; i < 20; i++) begin
            imem_ack  = 1'($urandom);
            imem_data = 16'($urandom);
            @(negedge clk);
            chk("halt_req", 16'(imem_req), 16'd0);
            chk("halt_flag", 16'(halted), 16'd1);
            chk("halt_pc", pc, m_pc);
        end
        imem_ack = 1'b0;

        rst = 1'b1;
        #1;
        chk("rst_halt_clr", 16'(halted), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rel2_req", 16'(imem_req), 16'd1);
        exec(enc(3, 1, 0, 0, 0), 0);   // R1 = 1
        exec(enc(5, 2, 1, 1, 0), 0);   // R2 = 2, leaves nonzero operands

        // Reset during DECODE of the next instruction.
        chk("mid_req", 16'(imem_req), 16'd1);
        imem_ack  = 1'b1;
        imem_data = enc(5, 3, 1, 2, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_pc", pc, 16'h0000);
        chk("mid_req_rst", 16'(imem_req), 16'd0);
        chk("mid_op", 16'(alu_op), 16'd0);
        chk("mid_a", alu_a, 16'd0);
        chk("mid_b", alu_b, 16'd0);
        chk("mid_c", alu_c, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rel3_req", 16'(imem_req), 16'd1);
        chk("rel3_addr", imem_addr, 16'h0000);
        exec(enc(5, 1, 1, 2, 3), 0);   // operands all read back as zero
        exec(enc(5, 0, 4, 5, 6), 0);
        exec(enc(1, 2, 1, 0, 0), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
